clink_cc_trigger_scheduler: RTL and testbench
=============================================

Name: clink_cc_trigger_scheduler

Overview:
Sequences the Camera Link camera-control (CC) lines to run exposure-trigger bursts on the ZCU104 camera path. It sits behind the AXI Camera Link interface register block, which supplies its configuration and start/abort strobes and reads back its status. Each frame follows the same sequence: wait for link ready, drive a CC pulse, wait for the frame (FVAL) to start and end, then enforce the trigger period. It stops after the programmed number of frames, on abort, or on timeout.

Parameters:
CNT_WIDTH, 32, width of the period, pulse-width and timeout counters (clock cycles)
FRAME_WIDTH, 16, width of the frame counters
CC_WIDTH, 4, number of CC lines (CC1..CC4)

Ports:
s_axi_aclk  input  1  single clock for all logic
s_axi_aresetn  input  1  asynchronous active-low reset
cfg_period  input  CNT_WIDTH  cycles from one pulse rise to the next pulse rise (minimum)
cfg_pulse_width  input  CNT_WIDTH  CC high time in cycles; 0 is treated as 1
cfg_frame_count  input  FRAME_WIDTH  frames per burst; 0 means continuous until abort
cfg_timeout  input  CNT_WIDTH  maximum cycles from pulse rise to FVAL rise; 0 disables the timeout
cfg_cc_mask  input  CC_WIDTH  CC lines driven during the pulse
start  input  1  one-cycle start strobe
abort  input  1  one-cycle abort strobe
clink_ready  input  1  Camera Link receiver locked; already in the s_axi_aclk domain
fval  input  1  frame-valid level; already synchronized to s_axi_aclk
cc_out  output  CC_WIDTH  CC line drive
busy  output  1  high whenever the state is not IDLE
done  output  1  one-cycle pulse on normal burst completion or abort
timeout_err  output  1  sticky timeout flag; cleared by the next accepted start
frames_done  output  FRAME_WIDTH  frames completed in the current or last burst

Behaviour:
- Reset (async assert, sync release): state IDLE; cc_out=0, busy=0, done=0, timeout_err=0, frames_done=0; all counters 0.
- States: IDLE, WAIT_READY, PULSE, WAIT_FV_RISE, WAIT_FV_FALL, WAIT_PERIOD.
- IDLE:
  - start=1 latches all cfg_* inputs into shadow registers.
  - The same accepted start clears frames_done and timeout_err.
  - Next state is WAIT_READY.
  - cfg_* changes while busy have no effect.
- WAIT_READY: when clink_ready=1, next cycle enters PULSE with cc_out=mask. The period counter and timeout counter both start at 0 in that cycle.
- Start-to-pulse latency is 2 cycles when clink_ready is already 1.
- PULSE:
  - cc_out=mask for exactly max(pulse_width,1) cycles.
  - Then cc_out=0 and the state goes to WAIT_FV_RISE.
  - An FVAL rise during PULSE is recorded, and WAIT_FV_RISE is skipped (goes straight to WAIT_FV_FALL).
- WAIT_FV_RISE: on the fval 0->1 edge, go to WAIT_FV_FALL.
- WAIT_FV_FALL:
  - On the fval 1->0 edge, frames_done increments (saturates at all-ones).
  - If frame_count≠0 and frames_done+1==frame_count: go to IDLE and pulse done.
  - Otherwise go to WAIT_PERIOD.
- WAIT_PERIOD: when the period counter is ≥ period−1, go to PULSE (or to WAIT_READY if clink_ready=0). If the period already elapsed during the frame, the next pulse starts on the cycle after the FVAL fall.
- Period counter: counts every cycle from the pulse rise and saturates. The effective pulse interval is max(period, pulse + frame time + 1).
- Timeout:
  - The timeout counter runs from the pulse rise until the FVAL rise.
  - If timeout≠0 and the counter reaches timeout before the FVAL rise, set timeout_err.
  - In that case: force cc_out=0, go to IDLE, no done pulse.
- Abort:
  - In any non-IDLE state, on the next cycle: cc_out=0, go to IDLE, done pulse; frames_done is held.
  - Abort in IDLE is ignored.
  - start and abort in the same cycle: abort wins; the start is ignored.
- clink_ready falling mid-burst: the current pulse and frame complete; the next frame waits in WAIT_READY.
- start while busy is ignored.
- Reset asserted mid-pulse: cc_out drops to 0 asynchronously.
- All counters are unsigned; comparisons are at CNT_WIDTH.

Test Plan:
1. Single frame: mask=4'b0001, pulse=10, period=100, frames=1, clink_ready=1; fval high 5 cycles starting 20 cycles after the pulse rise.
   -> cc_out[0] high exactly 10 cycles starting 2 cycles after start; done one cycle after the fval fall; frames_done=1.
2. Period enforcement: frames=3, period=200, pulse=5; fval high cycles 10..40 after each pulse.
   -> pulse rises exactly 200 cycles apart; frames_done=3; one done pulse.
3. Long frame: period=50, fval high 100 cycles.
   -> the next pulse rises on the cycle after the fval fall.
4. Timeout: timeout=500, fval held 0.
   -> timeout_err=1 at 500 cycles after the pulse rise; busy=0; no done pulse.
   -> The next start clears timeout_err.
5. Continuous mode with abort: frames=0; abort asserted mid-PULSE on frame 4.
   -> cc_out=0 next cycle; done pulses; frames_done=3.
   -> A start in the same cycle as the abort is ignored.
6. Link drop and reset: clink_ready low before start.
   -> state holds WAIT_READY with cc_out=0; the pulse begins 1 cycle after clink_ready rises.
   -> Asserting s_axi_aresetn=0 mid-pulse clears all outputs immediately.

Source files
------------

// File: rtl/clink_cc_trigger_scheduler.sv
// Camera Link CC trigger scheduler.
// Runs bursts of exposure triggers on the CC lines. Each frame waits for link
// ready, drives a CC pulse, follows FVAL rise and fall, then holds off until the
// trigger period has elapsed. A burst ends after the programmed frame count,
// on abort, or on an FVAL timeout.
// The external reset asserts asynchronously. Its release is re-timed
// internally so that all state leaves reset on a clock edge.
module clink_cc_trigger_scheduler #(
   parameter int CNT_WIDTH   = 32,
   parameter int FRAME_WIDTH = 16,
   parameter int CC_WIDTH    = 4
) (
   input  logic                   s_axi_aclk,
   input  logic                   s_axi_aresetn,
   input  logic [CNT_WIDTH-1:0]   cfg_period,
   input  logic [CNT_WIDTH-1:0]   cfg_pulse_width,
   input  logic [FRAME_WIDTH-1:0] cfg_frame_count,
   input  logic [CNT_WIDTH-1:0]   cfg_timeout,
   input  logic [CC_WIDTH-1:0]    cfg_cc_mask,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   clink_ready,
   input  logic                   fval,
   output logic [CC_WIDTH-1:0]    cc_out,
   output logic                   busy,
   output logic                   done,
   output logic                   timeout_err,
   output logic [FRAME_WIDTH-1:0] frames_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_READY,
      S_PULSE,
      S_WAIT_FV_RISE,
      S_WAIT_FV_FALL,
      S_WAIT_PERIOD
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [FRAME_WIDTH:0] FR_ONE  = (FRAME_WIDTH + 1)'(1);

   // Saturating increment for cycle counters.
   function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
      cnt_inc = (v == '1) ? v : v + CNT_ONE;
   endfunction

   // Saturating increment for the frame counter.
   function automatic logic [FRAME_WIDTH-1:0] frm_inc(input logic [FRAME_WIDTH-1:0] v);
      frm_inc = (v == '1) ? v : v + FRAME_WIDTH'(1);
   endfunction

   logic [1:0]             rst_sync_q, rst_sync_d;
   logic                   rst_n;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   period_q, period_d;
   logic [CNT_WIDTH-1:0]   pw_q, pw_d;
   logic [FRAME_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_WIDTH-1:0]   tmo_q, tmo_d;
   logic [CC_WIDTH-1:0]    mask_q, mask_d;
   logic [CNT_WIDTH-1:0]   per_cnt_q, per_cnt_d;
   logic [CNT_WIDTH-1:0]   pw_cnt_q, pw_cnt_d;
   logic [CNT_WIDTH-1:0]   to_cnt_q, to_cnt_d;
   logic                   rise_seen_q, rise_seen_d;
   logic                   fval_q, fval_d;
   logic [FRAME_WIDTH-1:0] frames_q, frames_d;
   logic                   done_q, done_d;
   logic                   terr_q, terr_d;

   logic                   start_ok, abort_ok;
   logic                   fval_rise, fval_fall;
   logic [CNT_WIDTH-1:0]   pw_eff;
   logic                   pulse_end, period_elapsed;
   logic                   tmo_active, tmo_hit, last_frame, frame_end, pulse_entry;

   // Reset release re-timing: next value of the two-stage release chain.
   always_comb begin
      rst_sync_d = {rst_sync_q[0], 1'b1};
   end

   // Reset release chain; clears immediately on external reset assertion.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) rst_sync_q <= 2'b00;
      else                rst_sync_q <= rst_sync_d;
   end

   assign rst_n = rst_sync_q[1];

   // Shared decode: edges, pulse/period/timeout conditions, frame completion.
   always_comb begin
      start_ok       = start & ~abort;
      abort_ok       = abort & (state_q != S_IDLE);
      fval_rise      = fval & ~fval_q;
      fval_fall      = ~fval & fval_q;
      pw_eff         = (pw_q == '0) ? CNT_ONE : pw_q;
      pulse_end      = (pw_cnt_q >= pw_eff - CNT_ONE);
      period_elapsed = (period_q == '0) || (per_cnt_q >= period_q - CNT_ONE);
      // The timeout window closes once FVAL has risen, even if still in PULSE.
      tmo_active     = ((state_q == S_PULSE) && !rise_seen_q) || (state_q == S_WAIT_FV_RISE);
      tmo_hit        = tmo_active && (tmo_q != '0) && (to_cnt_q >= tmo_q - CNT_ONE) && !fval_rise;
      last_frame     = (frame_cnt_q != '0) && (({1'b0, frames_q} + FR_ONE) == {1'b0, frame_cnt_q});
      frame_end      = (state_q == S_WAIT_FV_FALL) && fval_fall;
   end

   // Next-state logic; abort outranks timeout, which outranks normal sequencing.
   always_comb begin
      state_d = state_q;
      if (abort_ok) begin
         state_d = S_IDLE;
      end else if (tmo_hit) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:         if (start_ok) state_d = S_WAIT_READY;
            S_WAIT_READY:   if (clink_ready) state_d = S_PULSE;
            S_PULSE:        if (pulse_end)
                               state_d = (rise_seen_q || fval_rise) ? S_WAIT_FV_FALL : S_WAIT_FV_RISE;
            S_WAIT_FV_RISE: if (fval_rise) state_d = S_WAIT_FV_FALL;
            S_WAIT_FV_FALL: if (fval_fall) begin
                               if (last_frame)          state_d = S_IDLE;
                               else if (!period_elapsed) state_d = S_WAIT_PERIOD;
                               else if (clink_ready)     state_d = S_PULSE;
                               else                      state_d = S_WAIT_READY;
                            end
            S_WAIT_PERIOD:  if (period_elapsed) state_d = clink_ready ? S_PULSE : S_WAIT_READY;
            default:        state_d = S_IDLE;
         endcase
      end
   end

   // Datapath: shadow config, cycle counters, frame count and status flags.
   always_comb begin
      pulse_entry = (state_d == S_PULSE) && (state_q != S_PULSE);
      period_d    = period_q;
      pw_d        = pw_q;
      frame_cnt_d = frame_cnt_q;
      tmo_d       = tmo_q;
      mask_d      = mask_q;
      frames_d    = frames_q;
      terr_d      = terr_q;
      fval_d      = fval;
      done_d      = abort_ok || (frame_end && last_frame && !abort);
      if ((state_q == S_IDLE) && start_ok) begin
         period_d    = cfg_period;
         pw_d        = cfg_pulse_width;
         frame_cnt_d = cfg_frame_count;
         tmo_d       = cfg_timeout;
         mask_d      = cfg_cc_mask;
         frames_d    = '0;
         terr_d      = 1'b0;
      end
      if (frame_end && !abort) frames_d = frm_inc(frames_q);
      if (tmo_hit && !abort)   terr_d   = 1'b1;
      // Period and timeout counters restart on the first cycle of every pulse.
      if (state_q == S_IDLE || pulse_entry) begin
         per_cnt_d   = '0;
         to_cnt_d    = '0;
         pw_cnt_d    = '0;
         rise_seen_d = 1'b0;
      end else begin
         per_cnt_d   = cnt_inc(per_cnt_q);
         to_cnt_d    = tmo_active ? cnt_inc(to_cnt_q) : to_cnt_q;
         pw_cnt_d    = (state_q == S_PULSE) ? cnt_inc(pw_cnt_q) : pw_cnt_q;
         rise_seen_d = rise_seen_q || ((state_q == S_PULSE) && fval_rise);
      end
   end

   // State and datapath registers.
   always_ff @(posedge s_axi_aclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         period_q    <= '0;
         pw_q        <= '0;
         frame_cnt_q <= '0;
         tmo_q       <= '0;
         mask_q      <= '0;
         per_cnt_q   <= '0;
         pw_cnt_q    <= '0;
         to_cnt_q    <= '0;
         rise_seen_q <= 1'b0;
         fval_q      <= 1'b0;
         frames_q    <= '0;
         done_q      <= 1'b0;
         terr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         period_q    <= period_d;
         pw_q        <= pw_d;
         frame_cnt_q <= frame_cnt_d;
         tmo_q       <= tmo_d;
         mask_q      <= mask_d;
         per_cnt_q   <= per_cnt_d;
         pw_cnt_q    <= pw_cnt_d;
         to_cnt_q    <= to_cnt_d;
         rise_seen_q <= rise_seen_d;
         fval_q      <= fval_d;
         frames_q    <= frames_d;
         done_q      <= done_d;
         terr_q      <= terr_d;
      end
   end

   // Outputs: CC lines are driven only in PULSE, so any exit drops them.
   always_comb begin
      cc_out      = (state_q == S_PULSE) ? mask_q : '0;
      busy        = (state_q != S_IDLE);
      done        = done_q;
      timeout_err = terr_q;
      frames_done = frames_q;
   end

endmodule

// File: tb/tb_clink_cc_trigger_scheduler.sv
// Bench for clink_cc_trigger_scheduler: directed bursts with hand-computed
// event cycles; a negedge monitor matches observed CC/done/timeout events
// against an expectation queue.
module tb_clink_cc_trigger_scheduler;
   localparam int CW  = 32;
   localparam int FW  = 16;
   localparam int CCW = 4;

   localparam int K_RISE = 0;
   localparam int K_FALL = 1;
   localparam int K_DONE = 2;
   localparam int K_TERR = 3;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [CW-1:0]  cfg_period, cfg_pulse_width, cfg_timeout;
   logic [FW-1:0]  cfg_frame_count;
   logic [CCW-1:0] cfg_cc_mask;
   logic           start, abort, clink_ready, fval;
   logic [CCW-1:0] cc_out;
   logic           busy, done, timeout_err;
   logic [FW-1:0]  frames_done;

   typedef struct {
      int kind;
      int cyc;
      int val;
   } ev_t;

   ev_t exp_q[$];
   int  n_vec = 0;
   int  n_err = 0;
   int  cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   clink_cc_trigger_scheduler #(.CNT_WIDTH(CW), .FRAME_WIDTH(FW), .CC_WIDTH(CCW)) dut (
      .s_axi_aclk     (clk),
      .s_axi_aresetn  (rst_n),
      .cfg_period     (cfg_period),
      .cfg_pulse_width(cfg_pulse_width),
      .cfg_frame_count(cfg_frame_count),
      .cfg_timeout    (cfg_timeout),
      .cfg_cc_mask    (cfg_cc_mask),
      .start          (start),
      .abort          (abort),
      .clink_ready    (clink_ready),
      .fval           (fval),
      .cc_out         (cc_out),
      .busy           (busy),
      .done           (done),
      .timeout_err    (timeout_err),
      .frames_done    (frames_done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push(input int kind, input int c, input int val);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input int val);
      ev_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_event: got kind %0d val %0d at cycle %0d, required none", kind, val, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != cyc || e.val != val) begin
            n_err++;
            $display("FAIL event: got kind %0d val %0d at cycle %0d, required kind %0d val %0d at cycle %0d",
                     kind, val, cyc, e.kind, e.val, e.cyc);
         end
      end
   endtask

   // Monitor: derive events from the outputs at each falling edge.
   logic [CCW-1:0] prev_cc   = '0;
   logic           prev_terr = 1'b0;
   always @(negedge clk) begin
      if (cc_out != '0 && prev_cc == '0) observe(K_RISE, int'(cc_out));
      if (cc_out == '0 && prev_cc != '0) observe(K_FALL, 0);
      if (done === 1'b1)                 observe(K_DONE, int'(frames_done));
      if (timeout_err === 1'b1 && prev_terr == 1'b0) observe(K_TERR, int'(frames_done));
      prev_cc   = cc_out;
      prev_terr = timeout_err;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic do_start(output int s);
      s     = cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic fval_pulse(input int a, input int b);
      run_to(a);
      fval = 1'b1;
      run_to(b + 1);
      fval = 1'b0;
   endtask

   task automatic set_cfg(input int per, input int pw, input int frm, input int tmo, input int msk);
      cfg_period      = CW'(per);
      cfg_pulse_width = CW'(pw);
      cfg_frame_count = FW'(frm);
      cfg_timeout     = CW'(tmo);
      cfg_cc_mask     = CCW'(msk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, r, r0, r1, c;
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      clink_ready = 1'b1;
      fval = 1'b0;
      set_cfg(0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) tick();

      // Reset state
      chk("rst_cc_out", 32'(cc_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_timeout_err", 32'(timeout_err), 0);
      chk("rst_frames_done", 32'(frames_done), 0);

      // 1: single frame
      set_cfg(100, 10, 1, 0, 4'b0001);
      tick();
      do_start(s);
      r = s + 2;
      push(K_RISE, r, 1);
      push(K_FALL, r + 10, 0);
      push(K_DONE, r + 26, 1);
      fval_pulse(r + 20, r + 24);
      run_to(r + 30);
      chk("t1_busy", 32'(busy), 0);
      chk("t1_frames", 32'(frames_done), 1);
      chk("t1_drain", 32'(exp_q.size()), 0);

      // 2: period enforcement, config changes while busy ignored
      set_cfg(200, 5, 3, 0, 4'b0101);
      tick();
      do_start(s);
      r0 = s + 2;
      set_cfg(7, 1, 1, 3, 4'b1111);
      for (int k = 0; k < 3; k++) begin
         push(K_RISE, r0 + 200 * k, 5);
         push(K_FALL, r0 + 200 * k + 5, 0);
      end
      push(K_DONE, r0 + 442, 3);
      for (int k = 0; k < 3; k++) fval_pulse(r0 + 200 * k + 10, r0 + 200 * k + 40);
      run_to(r0 + 450);
      chk("t2_busy", 32'(busy), 0);
      chk("t2_frames", 32'(frames_done), 3);
      chk("t2_drain", 32'(exp_q.size()), 0);

      // 3: long frame, next pulse right after FVAL fall
      set_cfg(50, 5, 2, 0, 4'b1000);
      tick();
      do_start(s);
      r0 = s + 2;
      r1 = r0 + 111;
      push(K_RISE, r0, 8);
      push(K_FALL, r0 + 5, 0);
      push(K_RISE, r1, 8);
      push(K_FALL, r1 + 5, 0);
      push(K_DONE, r1 + 21, 2);
      fval_pulse(r0 + 10, r0 + 109);
      fval_pulse(r1 + 10, r1 + 19);
      run_to(r1 + 25);
      chk("t3_frames", 32'(frames_done), 2);
      chk("t3_drain", 32'(exp_q.size()), 0);

      // 4: timeout, then the next start clears the flag
      set_cfg(100, 10, 1, 500, 4'b0010);
      tick();
      do_start(s);
      r = s + 2;
      push(K_RISE, r, 2);
      push(K_FALL, r + 10, 0);
      push(K_TERR, r + 500, 0);
      run_to(r + 499);
      chk("t4_terr_early", 32'(timeout_err), 0);
      chk("t4_busy_early", 32'(busy), 1);
      tick();
      chk("t4_terr", 32'(timeout_err), 1);
      chk("t4_busy", 32'(busy), 0);
      run_to(r + 505);
      chk("t4_terr_sticky", 32'(timeout_err), 1);
      set_cfg(100, 10, 1, 0, 4'b0010);
      do_start(s);
      chk("t4_terr_cleared", 32'(timeout_err), 0);
      push(K_RISE, s + 2, 2);
      push(K_FALL, s + 4, 0);
      push(K_DONE, s + 4, 0);
      run_to(s + 3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      run_to(s + 8);
      chk("t4_drain", 32'(exp_q.size()), 0);

      // 5: continuous mode, abort with simultaneous start on frame 4
      set_cfg(30, 8, 0, 0, 4'b1111);
      tick();
      do_start(s);
      r0 = s + 2;
      for (int k = 0; k < 4; k++) begin
         push(K_RISE, r0 + 30 * k, 15);
         if (k < 3) push(K_FALL, r0 + 30 * k + 8, 0);
      end
      push(K_FALL, r0 + 94, 0);
      push(K_DONE, r0 + 94, 3);
      for (int k = 0; k < 3; k++) fval_pulse(r0 + 30 * k + 10, r0 + 30 * k + 14);
      run_to(r0 + 93);
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      run_to(r0 + 100);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_frames", 32'(frames_done), 3);
      chk("t5_drain", 32'(exp_q.size()), 0);

      // 6: link not ready at start, then reset mid-pulse
      clink_ready = 1'b0;
      set_cfg(100, 20, 1, 0, 4'b0011);
      tick();
      do_start(s);
      run_to(s + 10);
      chk("t6_wait_busy", 32'(busy), 1);
      chk("t6_wait_cc", 32'(cc_out), 0);
      c = cyc;
      clink_ready = 1'b1;
      push(K_RISE, c + 1, 3);
      push(K_FALL, c + 5, 0);
      run_to(c + 5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_cc", 32'(cc_out), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_done", 32'(done), 0);
      chk("t6_rst_terr", 32'(timeout_err), 0);
      chk("t6_rst_frames", 32'(frames_done), 0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (6) tick();
      chk("t6_post_busy", 32'(busy), 0);
      chk("t6_drain", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
